// File: rtl/cvxif_issue_ctrl.sv
// Issue-side controller for the CV-X-IF coprocessor port.
// Round-robin arbitration of NR_REQ offload requesters onto one issue channel,
// outstanding-instruction credit tracking, and a small FIFO that turns rejected
// offloads into illegal-instruction reports for writeback.
module cvxif_issue_ctrl #(
    parameter int NR_REQ    = 2,
    parameter int ID_W      = 3,
    parameter int MAX_OUTST = 4,
    parameter int ILL_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_REQ-1:0]              req_valid_i,
    output logic [NR_REQ-1:0]              req_ready_o,
    input  logic [NR_REQ*ID_W-1:0]         req_id_i,
    input  logic [NR_REQ*32-1:0]           req_instr_i,
    output logic                           issue_valid_o,
    input  logic                           issue_ready_i,
    input  logic                           issue_accept_i,
    output logic [ID_W-1:0]                issue_id_o,
    output logic [31:0]                    issue_instr_o,
    output logic [$clog2(NR_REQ)-1:0]      grant_o,
    input  logic                           result_valid_i,
    output logic                           ill_valid_o,
    output logic [ID_W-1:0]                ill_id_o,
    output logic [31:0]                    ill_instr_o,
    input  logic                           ill_ready_i,
    input  logic                           flush_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           err_o
);

    localparam int GW = $clog2(NR_REQ);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int PW = $clog2(ILL_DEPTH);
    localparam int CW = $clog2(ILL_DEPTH + 1);

    // Arbitration state
    logic [GW-1:0] rr_ptr;
    logic          lock_q;
    logic [GW-1:0] lock_idx;
    logic [GW-1:0] grant_scan;
    logic [GW-1:0] grant;
    logic [GW-1:0] grant_next;
    logic [GW:0]   scan_sum;
    logic [GW-1:0] scan_cand;
    logic          scan_found;

    // Credit state
    logic [OW-1:0] outst_q;
    logic          err_q;
    logic          outst_inc;
    logic          outst_dec;

    // Illegal-report FIFO state
    logic [ID_W-1:0] fifo_id    [ILL_DEPTH];
    logic [31:0]     fifo_instr [ILL_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full;
    logic            fifo_empty;

    // Handshake terms
    logic            can_issue;
    logic            issue_valid;
    logic            hs;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] sel_id;
    logic [31:0]     sel_instr;

    assign fifo_full  = (fifo_cnt == CW'(ILL_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    // Issue is held off during reset as well, so reset dominates all inputs.
    assign can_issue = (outst_q < OW'(MAX_OUTST)) && !fifo_full && !flush_i && !rst_i;

    // Round-robin scan starting at rr_ptr; falls back to rr_ptr when nobody requests.
    always_comb begin
        grant_scan = rr_ptr;
        scan_found = 1'b0;
        scan_sum   = '0;
        scan_cand  = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (GW+1)'(i);
            if (scan_sum >= (GW+1)'(NR_REQ)) begin
                scan_sum = scan_sum - (GW+1)'(NR_REQ);
            end
            scan_cand = scan_sum[GW-1:0];
            if (!scan_found && req_valid_i[scan_cand]) begin
                scan_found = 1'b1;
                grant_scan = scan_cand;
            end
        end
    end

    assign grant       = lock_q ? lock_idx : grant_scan;
    assign grant_next  = (grant == GW'(NR_REQ - 1)) ? '0 : grant + 1'b1;
    assign issue_valid = can_issue && req_valid_i[grant];
    assign hs          = issue_valid && issue_ready_i;
    assign push        = hs && !issue_accept_i;
    assign pop         = !fifo_empty && ill_ready_i;
    assign outst_inc   = hs && issue_accept_i;
    assign outst_dec   = result_valid_i && (outst_q != '0);

    assign sel_id    = req_id_i[int'(grant)*ID_W +: ID_W];
    assign sel_instr = req_instr_i[int'(grant)*32 +: 32];

    // Payload is presented only while the request is valid, otherwise zero.
    always_comb begin
        issue_id_o    = '0;
        issue_instr_o = '0;
        req_ready_o   = '0;
        if (issue_valid) begin
            issue_id_o    = sel_id;
            issue_instr_o = sel_instr;
        end
        if (hs) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    assign issue_valid_o = issue_valid;
    assign grant_o       = grant;
    assign outst_o       = outst_q;
    assign err_o         = err_q;

    // Lock holds the granted index across a stalled issue; rr advances past each winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_q   <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= grant_next;
            end
            if (flush_i || hs) begin
                lock_q <= 1'b0;
            end else if (issue_valid && !issue_ready_i) begin
                lock_q   <= 1'b1;
                lock_idx <= grant;
            end
        end
    end

    // Outstanding count: accept adds a credit back-pressure unit, result returns it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case ({outst_inc, outst_dec})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            if (result_valid_i && (outst_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; flush discards every queued report.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_i) begin
            rd_ptr   <= wr_ptr;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage needs no reset; entries are only read while occupancy covers them.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            fifo_id[wr_ptr]    <= sel_id;
            fifo_instr[wr_ptr] <= sel_instr;
        end
    end

    assign ill_valid_o = !fifo_empty;
    assign ill_id_o    = fifo_empty ? '0 : fifo_id[rd_ptr];
    assign ill_instr_o = fifo_empty ? '0 : fifo_instr[rd_ptr];

endmodule
